bcd_timer_nd: RTL and testbench

//  Parametrised N-digit BCD timer/counter with per-digit limits (e.g. 5/9 for mm:ss), up or down

---
 rtl/bcd_timer_nd_pkg.sv | 21 ++
 rtl/bcd_timer_nd_digit.sv | 41 ++++
 rtl/bcd_timer_nd.sv | 139 +++++++++++++
 tb/tb_bcd_timer_nd.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_timer_nd_pkg.sv
// Shared definitions for the N-digit BCD timer: digit width, FSM state
// encoding (also the encoding seen on the state output) and the per-digit
// load clamp.
package bcd_timer_nd_pkg;

    localparam int unsigned DIG_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Any nibble above its limit (including A-F) is pulled down to the limit.
    function automatic logic [DIG_W-1:0] clamp_digit(input logic [DIG_W-1:0] v,
                                                     input logic [DIG_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/bcd_timer_nd_digit.sv
// bcd_digit: one BCD digit of the timer chain.
// Ports:
//   clk, rst       clock, asynchronous active-low reset (val -> RST_VAL)
//   dec, inc       count down / count up this digit (never both high)
//   limit          maximum value of this digit
//   load, load_val synchronous load, takes priority over dec/inc
//   val            current digit value
//   borrow, carry  digit is wrapping on this dec/inc; feeds the next digit
module bcd_digit
    import bcd_timer_nd_pkg::*;
#(
    parameter logic [DIG_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec,
    input  logic             inc,
    input  logic [DIG_W-1:0] limit,
    input  logic             load,
    input  logic [DIG_W-1:0] load_val,
    output logic [DIG_W-1:0] val,
    output logic             borrow,
    output logic             carry
);

    assign borrow = dec & (val == '0);
    assign carry  = inc & (val == limit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val <= RST_VAL;
        end else if (load) begin
            val <= load_val;
        end else if (dec) begin
            val <= (val == '0) ? limit : val - DIG_W'(1);
        end else if (inc) begin
            val <= (val == limit) ? '0 : val + DIG_W'(1);
        end
    end

endmodule

// File: rtl/bcd_timer_nd.sv
// bcd_timer_nd: N-digit BCD timer/counter with per-digit limits, up/down
// counting, start/pause, load with clamping and stop-or-wrap at terminal.
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   tick      count-enable pulse
//   start     start/pause toggle pulse
//   clear     return to INIT and IDLE
//   load      load the clamped load_val (ignored while running)
//   load_val  packed BCD load value, digit0 in [3:0]
//   dir       0 = down, 1 = up
//   digits    packed BCD count, digit0 in [3:0]
//   state     00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//   running   state == RUN
//   done      WRAP=0: high in DONE; WRAP=1: one-cycle pulse on rollover
module bcd_timer_nd
    import bcd_timer_nd_pkg::*;
#(
    parameter int                     NDIG   = 4,
    parameter logic [DIG_W*NDIG-1:0]  LIMITS = 16'h5959,
    parameter logic [DIG_W*NDIG-1:0]  INIT   = 16'h0000,
    parameter bit                     WRAP   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  load,
    input  logic [DIG_W*NDIG-1:0] load_val,
    input  logic                  dir,
    output logic [DIG_W*NDIG-1:0] digits,
    output logic [1:0]            state,
    output logic                  running,
    output logic                  done
);

    localparam int W = DIG_W * NDIG;
    localparam logic [W-1:0] ONE = W'(1);

    state_t         state_q, state_n;
    logic           running_q, done_q, done_n;
    logic           cnt_do, digit_load, rollover;
    logic           at_term, pre_term;
    logic [W-1:0]   clamped, load_src;

    genvar i;
    generate
        for (i = 0; i < NDIG; i++) begin : g_dig
            logic             dig_dec, dig_inc, dig_borrow, dig_carry;
            logic [DIG_W-1:0] dig_val;

            assign clamped[DIG_W*i +: DIG_W] =
                clamp_digit(load_val[DIG_W*i +: DIG_W], LIMITS[DIG_W*i +: DIG_W]);

            if (i == 0) begin : g_lsb
                assign dig_dec = cnt_do & ~dir;
                assign dig_inc = cnt_do &  dir;
            end else begin : g_chain
                assign dig_dec = g_dig[i-1].dig_borrow;
                assign dig_inc = g_dig[i-1].dig_carry;
            end

            bcd_digit #(
                .RST_VAL (INIT[DIG_W*i +: DIG_W])
            ) u_digit (
                .clk      (clk),
                .rst      (rst),
                .dec      (dig_dec),
                .inc      (dig_inc),
                .limit    (LIMITS[DIG_W*i +: DIG_W]),
                .load     (digit_load),
                .load_val (load_src[DIG_W*i +: DIG_W]),
                .val      (dig_val),
                .borrow   (dig_borrow),
                .carry    (dig_carry)
            );

            assign digits[DIG_W*i +: DIG_W] = dig_val;
        end
    endgenerate

    // A borrow/carry out of the top digit is exactly a terminal rollover.
    assign rollover = g_dig[NDIG-1].dig_borrow | g_dig[NDIG-1].dig_carry;

    // pre_term: one count away from terminal in the current direction.
    // LIMITS-1 only touches digit0 since every limit is at least 1.
    assign at_term  = dir ? (digits == LIMITS)       : (digits == '0);
    assign pre_term = dir ? (digits == LIMITS - ONE) : (digits == ONE);

    always_comb begin
        state_n    = state_q;
        cnt_do     = 1'b0;
        digit_load = 1'b0;
        load_src   = clamped;
        if (clear) begin
            state_n    = ST_IDLE;
            digit_load = 1'b1;
            load_src   = INIT;
        end else if (load && state_q != ST_RUN) begin
            state_n    = ST_IDLE;
            digit_load = 1'b1;
        end else if (start) begin
            case (state_q)
                ST_IDLE, ST_PAUSE: state_n = (!WRAP && at_term) ? ST_DONE : ST_RUN;
                ST_RUN:            state_n = ST_PAUSE;
                default:           state_n = state_q;
            endcase
        end else if (tick && state_q == ST_RUN && !load) begin
            // Without wrap, a run that is already at terminal (after a dir
            // change) stops without counting.
            if (!WRAP && at_term) begin
                state_n = ST_DONE;
            end else begin
                cnt_do = 1'b1;
                if (!WRAP && pre_term) state_n = ST_DONE;
            end
        end
    end

    assign done_n = WRAP ? (cnt_do & rollover) : (state_n == ST_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            running_q <= (state_n == ST_RUN);
            done_q    <= done_n;
        end
    end

    assign state   = state_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_bcd_timer_nd.sv
module tb_bcd_timer_nd;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0, start = 1'b0, clear = 1'b0, load = 1'b0, dir = 1'b0;
    logic [15:0] lv = '0;

    logic [7:0]  dg_a, dg_b;
    logic [15:0] dg_c;
    logic [1:0]  st_a, st_b, st_c;
    logic        run_a, run_b, run_c, dn_a, dn_b, dn_c;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    bcd_timer_nd #(.NDIG(2), .LIMITS(8'h59), .INIT(8'h30), .WRAP(1'b0)) u_a (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .clear(clear), .load(load),
        .load_val(lv[7:0]), .dir(dir), .digits(dg_a), .state(st_a), .running(run_a), .done(dn_a));

    bcd_timer_nd #(.NDIG(2), .LIMITS(8'h59), .INIT(8'h30), .WRAP(1'b1)) u_b (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .clear(clear), .load(load),
        .load_val(lv[7:0]), .dir(dir), .digits(dg_b), .state(st_b), .running(run_b), .done(dn_b));

    bcd_timer_nd #(.NDIG(4), .LIMITS(16'h5959), .INIT(16'h0000), .WRAP(1'b0)) u_c (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .clear(clear), .load(load),
        .load_val(lv), .dir(dir), .digits(dg_c), .state(st_c), .running(run_c), .done(dn_c));

    // ---------------- behavioural model (count kept as a plain integer) ----
    int          nd[3]  = '{2, 2, 4};
    logic [31:0] lm[3]  = '{32'h59, 32'h59, 32'h5959};
    logic [31:0] ini[3] = '{32'h30, 32'h30, 32'h0};
    bit          wr[3]  = '{1'b0, 1'b1, 1'b0};
    string       nm[3]  = '{"A", "B", "C"};

    int m_n[3];
    int m_st[3];   // 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
    bit m_done[3];

    function automatic int lim_d(int k, int i);
        return int'(lm[k][4*i +: 4]);
    endfunction

    function automatic int total(int k);
        int t = 1;
        for (int i = 0; i < nd[k]; i++) t *= lim_d(k, i) + 1;
        return t;
    endfunction

    function automatic int to_idx(logic [31:0] bcd, int k);
        int idx = 0, w = 1;
        for (int i = 0; i < nd[k]; i++) begin
            idx += int'(bcd[4*i +: 4]) * w;
            w   *= lim_d(k, i) + 1;
        end
        return idx;
    endfunction

    function automatic logic [31:0] to_bcd(int n, int k);
        logic [31:0] r = '0;
        int v = n;
        for (int i = 0; i < nd[k]; i++) begin
            r[4*i +: 4] = 4'(v % (lim_d(k, i) + 1));
            v = v / (lim_d(k, i) + 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] clampv(logic [15:0] v, int k);
        logic [31:0] r = '0;
        for (int i = 0; i < nd[k]; i++)
            r[4*i +: 4] = (int'(v[4*i +: 4]) > lim_d(k, i)) ? 4'(lim_d(k, i)) : v[4*i +: 4];
        return r;
    endfunction

    function automatic bit is_term(int k, int n, bit d);
        return d ? (n == total(k) - 1) : (n == 0);
    endfunction

    task automatic model_step(int k);
        bit pulse = 1'b0;
        if (clear) begin
            m_n[k] = to_idx(ini[k], k); m_st[k] = 0;
        end else if (load && m_st[k] != 1) begin
            m_n[k] = to_idx(clampv(lv, k), k); m_st[k] = 0;
        end else if (start) begin
            if (m_st[k] == 0 || m_st[k] == 2)
                m_st[k] = (!wr[k] && is_term(k, m_n[k], dir)) ? 3 : 1;
            else if (m_st[k] == 1)
                m_st[k] = 2;
        end else if (tick && m_st[k] == 1 && !load) begin
            if (is_term(k, m_n[k], dir)) begin
                if (wr[k]) begin
                    m_n[k] = dir ? 0 : total(k) - 1;
                    pulse  = 1'b1;
                end else begin
                    m_st[k] = 3;
                end
            end else begin
                m_n[k] = dir ? m_n[k] + 1 : m_n[k] - 1;
                if (!wr[k] && is_term(k, m_n[k], dir)) m_st[k] = 3;
            end
        end
        m_done[k] = wr[k] ? pulse : (m_st[k] == 3);
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                m_n[k] = to_idx(ini[k], k); m_st[k] = 0; m_done[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) model_step(k);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    logic [31:0] dut_dg[3];
    logic [1:0]  dut_st[3];
    logic        dut_run[3], dut_dn[3];
    assign dut_dg[0] = {24'b0, dg_a};
    assign dut_dg[1] = {24'b0, dg_b};
    assign dut_dg[2] = {16'b0, dg_c};
    assign dut_st[0] = st_a;  assign dut_st[1] = st_b;  assign dut_st[2] = st_c;
    assign dut_run[0] = run_a; assign dut_run[1] = run_b; assign dut_run[2] = run_c;
    assign dut_dn[0] = dn_a;  assign dut_dn[1] = dn_b;  assign dut_dn[2] = dn_c;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk({nm[k], " digits"},  dut_dg[k], to_bcd(m_n[k], k));
            chk({nm[k], " state"},   32'(dut_st[k]), 32'(m_st[k]));
            chk({nm[k], " running"}, 32'(dut_run[k]), 32'(m_st[k] == 1));
            chk({nm[k], " done"},    32'(dut_dn[k]), 32'(m_done[k]));
        end
    end

    task automatic cyc(input bit t, input bit s, input bit c, input bit l, input logic [15:0] v);
        tick = t; start = s; clear = c; load = l; lv = v;
        @(posedge clk);
        #1;
        tick = 1'b0; start = 1'b0; clear = 1'b0; load = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset digits A", 32'(dg_a), 32'h30);
        chk("reset state A", 32'(st_a), 32'h0);
        chk("reset run/done A", 32'({run_a, dn_a}), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // 1: count 30 -> 00 and stop
        dir = 1'b0;
        cyc(0, 1, 0, 0, 16'h0);
        chk("t1 start state A", 32'(st_a), 32'h1);
        cyc(1, 0, 0, 0, 16'h0);
        chk("t1 first tick A", 32'(dg_a), 32'h29);
        repeat (28) cyc(1, 0, 0, 0, 16'h0);
        chk("t1 at 01 A", 32'({st_a, dg_a}), 32'h101);
        cyc(1, 0, 0, 0, 16'h0);
        chk("t1 done A", 32'({st_a, dn_a, dg_a}), 32'h700);
        repeat (3) cyc(1, 0, 0, 0, 16'h0);
        chk("t1 hold A", 32'({st_a, dg_a}), 32'h300);

        // 2: pause
        cyc(0, 0, 1, 0, 16'h0);
        cyc(0, 0, 0, 1, 16'h0025);
        chk("t2 load A", 32'({st_a, dg_a}), 32'h025);
        cyc(0, 1, 0, 0, 16'h0);
        cyc(0, 1, 0, 0, 16'h0);
        chk("t2 pause A", 32'({st_a, dg_a}), 32'h225);
        repeat (5) cyc(1, 0, 0, 0, 16'h0);
        chk("t2 paused ticks A", 32'({st_a, dg_a}), 32'h225);
        cyc(0, 1, 0, 0, 16'h0);
        cyc(1, 0, 0, 0, 16'h0);
        chk("t2 resume A", 32'({st_a, dg_a}), 32'h124);

        // 3: priority
        repeat (7) cyc(1, 0, 0, 0, 16'h0);
        cyc(1, 1, 0, 0, 16'h0);
        chk("t3 tick+start A", 32'({st_a, dg_a}), 32'h217);
        cyc(0, 0, 1, 1, 16'h0042);
        chk("t3 clear+load A", 32'({st_a, dg_a}), 32'h030);

        // 4: clamp, load ignored in RUN
        cyc(0, 0, 0, 1, 16'h007C);
        chk("t4 clamp A", 32'(dg_a), 32'h59);
        cyc(0, 1, 0, 0, 16'h0);
        cyc(0, 0, 0, 1, 16'h0011);
        chk("t4 load in run A", 32'({st_a, dg_a}), 32'h159);

        // 5: wrap on B
        cyc(0, 0, 1, 0, 16'h0);
        cyc(0, 0, 0, 1, 16'h0059);
        dir = 1'b1;
        cyc(0, 1, 0, 0, 16'h0);
        chk("t5 A start at up terminal", 32'({st_a, dn_a}), 32'h7);
        cyc(1, 0, 0, 0, 16'h0);
        chk("t5 wrap up B", 32'({st_b, dn_b, dg_b}), 32'h300);
        cyc(0, 0, 0, 0, 16'h0);
        chk("t5 pulse end B", 32'({st_b, dn_b, dg_b}), 32'h200);
        dir = 1'b0;
        cyc(1, 0, 0, 0, 16'h0);
        chk("t5 wrap down B", 32'({st_b, dn_b, dg_b}), 32'h359);

        // 6: four digits, borrow ripple, async reset mid-run
        cyc(0, 0, 1, 0, 16'h0);
        cyc(0, 0, 0, 1, 16'h1000);
        cyc(0, 1, 0, 0, 16'h0);
        cyc(1, 0, 0, 0, 16'h0);
        chk("t6 ripple C", 32'({st_c, dg_c}), 32'h10959);
        repeat (2) cyc(1, 0, 0, 0, 16'h0);
        chk("t6 run C", 32'(dg_c), 32'h0957);
        #2 rst = 1'b0;
        #1;
        chk("t6 async reset C", 32'({st_c, run_c, dg_c}), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // up count reaching terminal without wrap
        dir = 1'b1;
        cyc(0, 0, 0, 1, 16'h0057);
        cyc(0, 1, 0, 0, 16'h0);
        cyc(1, 0, 0, 0, 16'h0);
        chk("up 58 A", 32'({st_a, dg_a}), 32'h158);
        cyc(1, 0, 0, 0, 16'h0);
        chk("up done A", 32'({st_a, dn_a, dg_a}), 32'h759);

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
